rr_mux_arb: RTL and testbench
=============================

RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 WIDTH, 16, data width of every channel and of the output, in bits.
REQ-002 NCH, 8, number of input channels; legal range 2..16.
REQ-003 SELW, $clog2(NCH), width of the channel index; derived, never overridden.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_valid  in  NCH  per-channel request; bit i belongs to channel i.
REQ-007 in_data  in  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-008 in_last  in  NCH  per-channel end-of-packet marker.
REQ-009 in_ready  out  NCH  per-channel accept; a beat transfers on channel i when in_valid[i] and in_ready[i] are both 1.
REQ-010 out_valid  out  1  the output register holds a beat.
REQ-011 out_data  out  WIDTH  selected data.
REQ-012 out_last  out  1  in_last of the selected beat.
REQ-013 out_sel  out  SELW  index of the channel that supplied the beat.
REQ-014 out_ready  in  1  downstream accept; a beat leaves when out_valid and out_ready are both 1.

Function
REQ-015 The block has a single output register; load = !out_valid || out_ready.
REQ-016 Arbitration is combinational round-robin: search starts at ptr and wraps from NCH-1 to 0; the first channel with in_valid=1 wins.
REQ-017 At most one in_ready bit is 1 per cycle, and only the winner's; in_ready[g] = load && in_valid[g]; all bits are 0 when no channel is valid.
REQ-018 On transfer: out_data, out_last and out_sel load the winner's values, out_valid=1, and ptr becomes (g+1) mod NCH.
REQ-019 If out_valid && out_ready and no channel transfers, out_valid clears to 0 and data, last and sel hold their values.
REQ-020 Latency is one cycle from input transfer to out_valid; sustained throughput is one beat per cycle while out_ready=1.
REQ-021 When out_valid=1 and out_ready=0, all output fields hold stable and every in_ready bit is 0.
REQ-022 ptr moves only on a transfer; an idle cycle keeps ptr.
REQ-023 Each valid channel is granted within NCH transfers, so no channel starves.
REQ-024 in_valid may drop without a transfer and the block tolerates it; the output handshake never withdraws out_valid before acceptance.

Reset
REQ-025 While reset=1: out_valid=0, out_data=0, out_last=0, out_sel=0, ptr=0, lock=0, and all in_ready bits are 0.
REQ-026 Reset asserted mid-transfer discards the held beat with no partial output; on the first cycle after reset, channel 0 has highest priority.

Configuration
REQ-027 Macro RR_MUX_ARB_LOCK_EN enables packet locking.
REQ-028 With the macro defined: after a transfer with in_last=0, lock=1 and the grant is forced to out_sel, ignoring other channels; lock clears on the transfer carrying in_last=1, and ptr updates only on that beat.
REQ-029 Without the macro: every beat re-arbitrates; in_last is passed through to out_last only; the lock flop is absent.

Structure
REQ-030 A shared package holds the default WIDTH/NCH constants and the round-robin find-first function (request vector + start index -> index + found flag).
REQ-031 One sub-module, rr_arbiter (requests, ptr, lock, locked index -> grant index, grant valid), is instantiated once.

Verification
REQ-032 Reset, then in_valid=8'h00 -> out_valid=0 and in_ready=0 on every cycle.
REQ-033 in_valid=8'hFF, out_ready=1, data[i]=16'h1000+i -> out_sel sequence 0,1,…,7,0 on consecutive cycles, out_data=16'h1000+sel.
REQ-034 in_valid=8'h24, out_ready held 0 for 3 cycles after the first beat -> out_data stable and in_ready=0 while stalled; grants alternate 2,5,2.
REQ-035 With LOCK_EN defined, channel 3 sends 3 beats (last on the 3rd) while channel 1 is valid -> out_sel=3,3,3 then 1; without the macro -> 3,1,3,1.
REQ-036 Assert reset while out_valid=1, out_ready=0 -> next cycle out_valid=0 and out_sel=0; first grant after release goes to the lowest valid index.

Source files
------------

// File: rtl/rr_mux_arb_pkg.sv
// Shared constants and the round-robin search helper for rr_mux_arb.
// Latency: none; the package holds types, constants and a pure function only.
// Backpressure: not applicable.
package rr_mux_arb_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int NCH_DEF   = 8;
   localparam int NCH_MAX   = 16;

   typedef struct packed {
      logic       found;
      logic [3:0] idx;
   } rr_pick_t;

   // Returns the first set bit of req at or after start, wrapping at nch.
   // Bits at nch and above are never considered.
   function automatic rr_pick_t rr_find_first(input logic [NCH_MAX-1:0] req,
                                              input logic [3:0]         start,
                                              input int                 nch);
      rr_pick_t   pick;
      logic [3:0] j;
      pick = '0;
      for (int k = 0; k < NCH_MAX; k++) begin
         if (k < nch) begin
            j = 4'((int'(start) + k) % nch);
            if (!pick.found && req[j]) begin
               pick.found = 1'b1;
               pick.idx   = j;
            end
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_mux_arb_arbiter.sv
// Combinational round-robin arbiter with an optional forced (locked) grant.
// Latency: combinational. Backpressure: none; the caller gates the grant.
// Ports: req (one bit per channel), ptr (search start), lock and lock_idx
// (force the grant to lock_idx) -> gnt_idx, gnt_vld.
module rr_arbiter
   import rr_mux_arb_pkg::*;
#(
   parameter  int NCH  = NCH_DEF,
   localparam int SELW = $clog2(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   input  logic            lock,
   input  logic [SELW-1:0] lock_idx,
   output logic [SELW-1:0] gnt_idx,
   output logic            gnt_vld
);

   rr_pick_t pick;

   always_comb begin
      pick    = rr_find_first(NCH_MAX'(req), 4'(ptr), NCH);
      gnt_idx = SELW'(pick.idx);
      gnt_vld = pick.found;
      // A locked packet owns the output: only its channel may be granted,
      // and if it is momentarily not valid nobody else is.
      if (lock) begin
         gnt_idx = lock_idx;
         gnt_vld = req[lock_idx];
      end
   end

endmodule

// File: rtl/rr_mux_arb.sv
// Round-robin N:1 mux-arbiter into a single output register.
// Latency: 1 cycle from input transfer to out_valid; 1 beat/cycle sustained.
// Backpressure: out_ready=0 with out_valid=1 freezes the output and drops all in_ready.
// Ports: clk, reset (sync, active-high); in_valid/in_data/in_last/in_ready per
// channel; out_valid/out_data/out_last/out_sel/out_ready for the merged stream.
// Optional: define RR_MUX_ARB_LOCK_EN to hold the grant on a channel until its in_last beat.
module rr_mux_arb
   import rr_mux_arb_pkg::*;
#(
   parameter  int WIDTH = WIDTH_DEF,
   parameter  int NCH   = NCH_DEF,
   localparam int SELW  = $clog2(NCH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NCH-1:0]       in_valid,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_last,
   output logic [NCH-1:0]       in_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_last,
   output logic [SELW-1:0]      out_sel,
   input  logic                 out_ready
);

   logic [SELW-1:0]  ptr;
   logic [SELW-1:0]  ptr_next;
   logic [SELW-1:0]  gnt_idx;
   logic             gnt_vld;
   logic             load;
   logic             xfer;
   logic             lock;
   logic [WIDTH-1:0] win_data;

   rr_arbiter #(.NCH(NCH)) u_arb (
      .req      (in_valid),
      .ptr      (ptr),
      .lock     (lock),
      .lock_idx (out_sel),
      .gnt_idx  (gnt_idx),
      .gnt_vld  (gnt_vld)
   );

   always_comb begin
      load     = !out_valid || out_ready;
      xfer     = !reset && load && gnt_vld;
      win_data = in_data[gnt_idx*WIDTH +: WIDTH];
      ptr_next = (gnt_idx == SELW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
      in_ready = '0;
      if (xfer) begin
         in_ready[gnt_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= win_data;
         out_last  <= in_last[gnt_idx];
         out_sel   <= gnt_idx;
`ifdef RR_MUX_ARB_LOCK_EN
         // Fairness advances per packet, not per beat.
         if (in_last[gnt_idx]) begin
            ptr <= ptr_next;
         end
`else
         ptr <= ptr_next;
`endif
      end else if (out_ready) begin
         // Beat consumed with nothing new: drop valid, keep fields as they were.
         out_valid <= 1'b0;
      end
   end

`ifdef RR_MUX_ARB_LOCK_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         lock <= 1'b0;
      end else if (xfer) begin
         lock <= !in_last[gnt_idx];
      end
   end
`else
   assign lock = 1'b0;
`endif

endmodule

// File: tb/tb_rr_mux_arb.sv
// Bench for rr_mux_arb: directed scenarios followed by random traffic, all
// checked every cycle against a reference model of the arbitration rules.
module tb_rr_mux_arb;

   localparam int W = 16;
   localparam int N = 8;
`ifdef RR_MUX_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   in_valid;
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_last;
   logic [N-1:0]   in_ready;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic           out_last;
   logic [2:0]     out_sel;
   logic           out_ready;

   rr_mux_arb #(.WIDTH(W), .NCH(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mism     = 0;

   // Reference model state.
   logic [W-1:0] chd [N];
   bit           m_valid;
   logic [W-1:0] m_data;
   bit           m_last;
   int           m_sel;
   int           m_ptr;
   bit           m_lock;
   int           g;
   bit           found;
   bit           m_xfer;
   int           c3;
   int           exp35 [4];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mism++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: predict grant from current inputs, check in_ready, advance
   // the model at the edge, then check the registered outputs.
   task automatic tick();
      logic [N*W-1:0] pk;
      logic [N-1:0]   er;
      for (int i = 0; i < N; i++) pk[i*W +: W] = chd[i];
      in_data = pk;
      found = 1'b0;
      g     = 0;
      if (m_lock) begin
         g     = m_sel;
         found = in_valid[g];
      end else begin
         for (int k = 0; k < N; k++) begin
            if (!found && in_valid[(m_ptr + k) % N]) begin
               found = 1'b1;
               g     = (m_ptr + k) % N;
            end
         end
      end
      m_xfer = !reset && (!m_valid || out_ready) && found;
      er = '0;
      if (m_xfer) er[g] = 1'b1;
      #1;
      check("in_ready", 32'(in_ready), 32'(er));
      @(posedge clk);
      if (reset) begin
         m_valid = 0; m_data = '0; m_last = 0; m_sel = 0; m_ptr = 0; m_lock = 0;
      end else if (m_xfer) begin
         m_valid = 1;
         m_data  = chd[g];
         m_last  = in_last[g];
         m_sel   = g;
         if (LOCK_EN) begin
            if (in_last[g]) begin
               m_ptr  = (g + 1) % N;
               m_lock = 0;
            end else begin
               m_lock = 1;
            end
         end else begin
            m_ptr = (g + 1) % N;
         end
      end else if (m_valid && out_ready) begin
         m_valid = 0;
      end
      @(negedge clk);
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_data",  32'(out_data),  32'(m_data));
      check("out_last",  32'(out_last),  32'(m_last));
      check("out_sel",   32'(out_sel),   32'(m_sel));
   endtask

   initial begin
      for (int i = 0; i < N; i++) chd[i] = 16'h1000 + 16'(i);
      m_valid = 0; m_data = '0; m_last = 0; m_sel = 0; m_ptr = 0; m_lock = 0;
      reset = 1'b1; in_valid = '0; in_last = '1; out_ready = 1'b1; in_data = '0;
      @(negedge clk);

      // Reset holds everything at zero.
      repeat (3) tick();

      // Idle: nothing requested, nothing granted.
      reset = 1'b0;
      repeat (4) tick();

      // Full load: strict rotation 0..7 then back to 0.
      in_valid = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         tick();
         check("rr_seq_sel",  32'(out_sel),  32'(i % 8));
         check("rr_seq_data", 32'(out_data), 32'(16'h1000 + 16'(i % 8)));
      end

      // Two requesters with a stall after the first beat.
      in_valid = 8'h24;
      tick();
      check("alt_first", 32'(out_sel), 32'd2);
      out_ready = 1'b0;
      repeat (3) begin
         tick();
         check("stall_sel",  32'(out_sel),  32'd2);
         check("stall_data", 32'(out_data), 32'h1002);
      end
      out_ready = 1'b1;
      tick();
      check("alt_second", 32'(out_sel), 32'd5);
      tick();
      check("alt_third", 32'(out_sel), 32'd2);

      // Packet locking: ch3 sends 3 beats while ch1 competes.
      reset = 1'b1; in_valid = '0;
      repeat (2) tick();
      reset = 1'b0;
      in_valid = 8'h04; in_last = 8'hFF;
      tick();
      if (LOCK_EN) begin
         exp35[0] = 3; exp35[1] = 3; exp35[2] = 3; exp35[3] = 1;
      end else begin
         exp35[0] = 3; exp35[1] = 1; exp35[2] = 3; exp35[3] = 1;
      end
      c3 = 0;
      in_valid = 8'h0A;
      for (int b = 0; b < 4; b++) begin
         in_last = 8'hF7 | ((c3 == 2) ? 8'h08 : 8'h00);
         tick();
         if (m_xfer && g == 3) c3++;
         check("lock_seq", 32'(out_sel), 32'(exp35[b]));
      end

      // Reset while a beat is stalled in the output register.
      in_last = 8'hFF; in_valid = 8'h30; out_ready = 1'b0;
      repeat (2) tick();
      check("pre_reset_valid", 32'(out_valid), 32'd1);
      reset = 1'b1;
      tick();
      check("rst_mid_valid", 32'(out_valid), 32'd0);
      check("rst_mid_sel",   32'(out_sel),   32'd0);
      reset = 1'b0; in_valid = 8'h24; out_ready = 1'b1;
      tick();
      check("post_rst_grant", 32'(out_sel), 32'd2);

      // Random traffic, backpressure and occasional reset.
      for (int r = 0; r < 400; r++) begin
         in_valid  = 8'($urandom);
         in_last   = 8'($urandom);
         for (int i = 0; i < N; i++) chd[i] = 16'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         reset     = ($urandom_range(0, 63) == 0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end

endmodule
